mc_main_fsm: RTL and testbench

//  Multicycle main controller for the ARM-subset CPU. Sequences the shared datapath (single memory, one ALU)
//  per instruction: fetch, decode, address/execute, memory access, writeback. Emits raw enables
//  (RegW, MemW, PCS, FlagW, NextPC); the condition logic gates RegW/MemW/PCS/FlagW with CondEx.

---
 rtl/mc_main_fsm_pkg.sv | 55 +++++
 rtl/mc_main_fsm_if.sv | 44 ++++
 rtl/mc_alu_dec.sv | 56 +++++
 rtl/mc_main_fsm.sv | 174 +++++++++++++++++
 tb/tb_mc_main_fsm.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_main_fsm_pkg.sv
// mc_main_fsm_pkg
//   Shared definitions for the multicycle main controller: state encodings,
//   opcode classes, data-processing cmd codes, ALUControl codes and the
//   datapath mux select codes (ALUSrcA, ALUSrcB, ResultSrc).
//   No ports; imported by the controller and its ALU decoder.

package mc_main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    // Instr[27:26] opcode classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALUControl codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_main_fsm_if.sv
// mc_main_fsm_if
//   Bundle between the main controller and the datapath/memory side.
//   Instruction fields : Op[1:0], Funct[5:0], Rd[3:0]
//   Memory handshake   : MemReq (controller), mem_rdy (memory)
//   Datapath controls  : IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
//                        ALUControl, FlagW, RegW, MemW, PCS
//   modport master = controller, modport slave = datapath/memory.
//
// Handshake: the controller raises MemReq and holds it, with AdrSrc stable,
// until the cycle in which mem_rdy=1; that cycle completes the transfer.
// A new request may start in the very next cycle. mem_rdy has no meaning
// while MemReq is low.

interface mc_main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       mem_rdy;

    logic       MemReq;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] FlagW;
    logic       RegW;
    logic       MemW;
    logic       PCS;

    modport master (
        input  Op, Funct, Rd, mem_rdy,
        output MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUControl, FlagW, RegW, MemW, PCS
    );

    modport slave (
        output Op, Funct, Rd, mem_rdy,
        input  MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUControl, FlagW, RegW, MemW, PCS
    );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec
//   Combinational ALU decoder for data-processing instructions.
//   Ports:
//     Funct      in  6  [4:1] = cmd, [0] = S
//     alu_op     in  1  controller is in an execute state
//     ALUControl out 2  ADD/SUB/AND/ORR
//     FlagW      out 2  [1] = N,Z write, [0] = C,V write (raw)
//   Unrecognised cmds fall back to ADD with no flag writes.

module mc_alu_dec
    import mc_main_fsm_pkg::*;
(
    input  logic [5:0] Funct,
    input  logic       alu_op,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW
);

    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_i_bit;

    assign cmd          = Funct[4:1];
    assign s_bit        = Funct[0];
    assign unused_i_bit = Funct[5];

    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: begin
                    ALUControl = ALU_ADD;
                    FlagW      = {s_bit, s_bit};
                end
                CMD_SUB: begin
                    ALUControl = ALU_SUB;
                    FlagW      = {s_bit, s_bit};
                end
                CMD_AND: begin
                    ALUControl = ALU_AND;
                    FlagW      = {s_bit, 1'b0};
                end
                CMD_ORR: begin
                    ALUControl = ALU_ORR;
                    FlagW      = {s_bit, 1'b0};
                end
                default: begin
                    ALUControl = ALU_ADD;
                    FlagW      = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_main_fsm.sv
// mc_main_fsm
//   Multicycle main controller for the ARM-subset CPU. Walks each instruction
//   through fetch, decode, address/execute, memory access and writeback on a
//   shared datapath, emitting raw enables that the condition logic gates.
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   synchronous active-low reset
//     bus      master modport of mc_main_fsm_if (instruction fields,
//              memory handshake, datapath controls)
//     illegal  out  sticky: an illegal opcode has been decoded
//     state_o  out  current state (debug)

module mc_main_fsm
    import mc_main_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    mc_main_fsm_if.master      bus,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_t state;
    state_t next_state;

    logic       mem_req;
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic [1:0] flag_w_raw;
    logic [1:0] alu_control;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Raised on the decode edge so it is visible from the first UNKNOWN cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else if (next_state == S_UNKNOWN) begin
            illegal <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:   next_state = bus.mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_DP:   next_state = bus.Funct[5] ? S_EXECI : S_EXECR;
                    OP_MEM:  next_state = S_MEMADR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_UNKNOWN;
                endcase
            end
            S_MEMADR:  next_state = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = bus.mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = bus.mem_rdy ? S_FETCH : S_MEMWR;
            S_EXECR:   next_state = S_ALUWB;
            S_EXECI:   next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_UNKNOWN: next_state = S_UNKNOWN;
            default:   next_state = S_FETCH;
        endcase
    end

    // Moore output decode; IRWrite/NextPC/MemW additionally wait for mem_rdy
    always_comb begin
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = bus.mem_rdy;
                next_pc    = bus.mem_rdy;
            end
            S_DECODE: begin
                // PC+4 again, which reads as PC+8 for R15 operands
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_MEMADR: begin
                alu_src_b  = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_w      = bus.mem_rdy;
            end
            S_EXECR: begin
                alu_op     = 1'b1;
            end
            S_EXECI: begin
                alu_src_b  = SRCB_IMM;
                alu_op     = 1'b1;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    mc_alu_dec u_alu_dec (
        .Funct      (bus.Funct),
        .alu_op     (alu_op),
        .ALUControl (alu_control),
        .FlagW      (flag_w_raw)
    );

    // Enables are forced low while reset is held so a reset landing
    // mid-handshake never leaves a request or write pulse on the bus.
    assign bus.MemReq     = reset & mem_req;
    assign bus.IRWrite    = reset & ir_write;
    assign bus.NextPC     = reset & next_pc;
    assign bus.RegW       = reset & reg_w;
    assign bus.MemW       = reset & mem_w;
    assign bus.PCS        = reset & (branch | (reg_w & (bus.Rd == 4'hF)));
    assign bus.FlagW      = reset ? flag_w_raw : 2'b00;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;

    assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm
//   Directed bench for the multicycle main controller. A per-cycle vector
//   table drives the instruction fields, mem_rdy and reset, and gives the
//   expected outputs for that cycle; hand-written sequences cover the
//   illegal-opcode lock-up and reset landing inside a store handshake.

module tb_mc_main_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq;
        logic       irw;
        logic       npc;
        logic       adr;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] ac;
        logic [1:0] fw;
        logic       rw;
        logic       mw;
        logic       pcs;
        logic       ill;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam int OUT_W = $bits(out_t);

    localparam logic [5:0] F_ADDSI = 6'b101001;  // I=1 ADD  S=1
    localparam logic [5:0] F_SUBSR = 6'b000101;  // I=0 SUB  S=1
    localparam logic [5:0] F_ANDR  = 6'b000000;  // I=0 AND  S=0
    localparam logic [5:0] F_BADI  = 6'b111111;  // I=1 cmd 1111 S=1
    localparam logic [5:0] F_LDR   = 6'b011001;  // L=1
    localparam logic [5:0] F_STR   = 6'b011000;  // L=0
    localparam logic [5:0] F_ORRSR = 6'b011001;  // I=0 ORR  S=1

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset;
    logic       illegal;
    logic [3:0] state_o;

    mc_main_fsm_if bus ();

    mc_main_fsm #(.STATE_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .illegal (illegal),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [OUT_W-1:0] exp_q[$];
    int n_checks;
    int n_fail;
    vec_t vecs[$];

    function automatic out_t o(input int st, input int mreq, input int irw, input int npc,
                               input int adr, input int sa, input int sb, input int rs,
                               input int ac, input int fw, input int rw, input int mw,
                               input int pcs, input int ill);
        out_t r;
        r.st   = 4'(st);
        r.mreq = 1'(mreq);
        r.irw  = 1'(irw);
        r.npc  = 1'(npc);
        r.adr  = 1'(adr);
        r.sa   = 2'(sa);
        r.sb   = 2'(sb);
        r.rs   = 2'(rs);
        r.ac   = 2'(ac);
        r.fw   = 2'(fw);
        r.rw   = 1'(rw);
        r.mw   = 1'(mw);
        r.pcs  = 1'(pcs);
        r.ill  = 1'(ill);
        return r;
    endfunction

    function automatic vec_t mk(input int rst, input int op, input logic [5:0] funct,
                                input int rd, input int rdy, input out_t exp);
        vec_t v;
        v.rst   = 1'(rst);
        v.op    = 2'(op);
        v.funct = funct;
        v.rd    = 4'(rd);
        v.rdy   = 1'(rdy);
        v.exp   = exp;
        return v;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.st   = state_o;
        a.mreq = bus.MemReq;
        a.irw  = bus.IRWrite;
        a.npc  = bus.NextPC;
        a.adr  = bus.AdrSrc;
        a.sa   = bus.ALUSrcA;
        a.sb   = bus.ALUSrcB;
        a.rs   = bus.ResultSrc;
        a.ac   = bus.ALUControl;
        a.fw   = bus.FlagW;
        a.rw   = bus.RegW;
        a.mw   = bus.MemW;
        a.pcs  = bus.PCS;
        a.ill  = illegal;
        return a;
    endfunction

    // ---------------- driver ----------------
    // Called just after a falling edge: drive, settle, compare, move to next falling edge.
    task automatic apply(input vec_t v, input string name);
        out_t act;
        out_t exp;
        reset       = v.rst;
        bus.Op      = v.op;
        bus.Funct   = v.funct;
        bus.Rd      = v.rd;
        bus.mem_rdy = v.rdy;
        exp_q.push_back(v.exp);
        #1;
        act = sample();
        exp = out_t'(exp_q.pop_front());
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h (state %0d) required=%h (state %0d)",
                     name, act, act.st, exp, exp.st);
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.Op      = 2'b00;
        bus.Funct   = 6'b000000;
        bus.Rd      = 4'd0;
        bus.mem_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset held in FETCH: enables forced low, muxes still decoded
        vecs.push_back(mk(0, 0, F_ADDSI, 3, 1, o(0,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        // ADDS imm, Rd=3
        vecs.push_back(mk(1, 0, F_ADDSI, 3, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ADDSI, 3, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ADDSI, 3, 1, o(7,0,0,0,0,0,1,0,0,3,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ADDSI, 3, 1, o(8,0,0,0,0,0,0,0,0,0,1,0,0,0)));
        // ADDS imm, Rd=15 -> PCS in writeback
        vecs.push_back(mk(1, 0, F_ADDSI, 15, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ADDSI, 15, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ADDSI, 15, 1, o(7,0,0,0,0,0,1,0,0,3,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ADDSI, 15, 1, o(8,0,0,0,0,0,0,0,0,0,1,0,1,0)));
        // SUBS reg, Rd=2
        vecs.push_back(mk(1, 0, F_SUBSR, 2, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_SUBSR, 2, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_SUBSR, 2, 1, o(6,0,0,0,0,0,0,0,1,3,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_SUBSR, 2, 1, o(8,0,0,0,0,0,0,0,0,0,1,0,0,0)));
        // AND reg, no S
        vecs.push_back(mk(1, 0, F_ANDR, 1, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ANDR, 1, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ANDR, 1, 1, o(6,0,0,0,0,0,0,0,2,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_ANDR, 1, 1, o(8,0,0,0,0,0,0,0,0,0,1,0,0,0)));
        // Unlisted cmd: ADD, no flags, still writes back
        vecs.push_back(mk(1, 0, F_BADI, 6, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_BADI, 6, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_BADI, 6, 1, o(7,0,0,0,0,0,1,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 0, F_BADI, 6, 1, o(8,0,0,0,0,0,0,0,0,0,1,0,0,0)));
        // FETCH waits 4 cycles, then LDR with 2 wait cycles in MEMRD
        vecs.push_back(mk(1, 1, F_LDR, 5, 0, o(0,1,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 0, o(0,1,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 0, o(0,1,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 0, o(0,1,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 1, o(2,0,0,0,0,0,1,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 0, o(3,1,0,0,1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 0, o(3,1,0,0,1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 1, o(3,1,0,0,1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_LDR, 5, 0, o(4,0,0,0,0,0,0,1,0,0,1,0,0,0)));
        // STR with 3 wait cycles; MemW only in the rdy cycle
        vecs.push_back(mk(1, 1, F_STR, 5, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_STR, 5, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_STR, 5, 1, o(2,0,0,0,0,0,1,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_STR, 5, 0, o(5,1,0,0,1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_STR, 5, 0, o(5,1,0,0,1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_STR, 5, 0, o(5,1,0,0,1,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 1, F_STR, 5, 1, o(5,1,0,0,1,0,0,0,0,0,0,1,0,0)));
        // Branch
        vecs.push_back(mk(1, 2, F_ANDR, 0, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 2, F_ANDR, 0, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)));
        vecs.push_back(mk(1, 2, F_ANDR, 0, 1, o(9,0,0,0,0,0,1,2,0,0,0,0,1,0)));
        vecs.push_back(mk(1, 2, F_ANDR, 0, 0, o(0,1,0,0,0,1,2,2,0,0,0,0,0,0)));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Illegal opcode: lock in UNKNOWN, ignore mem_rdy and opcode changes
        apply(mk(1, 3, F_ANDR, 0, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)), "ill_fetch");
        apply(mk(1, 3, F_ANDR, 0, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)), "ill_decode");
        for (int i = 0; i < 12; i++) begin
            apply(mk(1, i % 4, F_ADDSI, 15, i % 2, o(10,0,0,0,0,0,0,0,0,0,0,0,0,1)),
                  $sformatf("unk%0d", i));
        end
        apply(mk(0, 0, F_ADDSI, 15, 1, o(10,0,0,0,0,0,0,0,0,0,0,0,0,1)), "unk_rst");
        apply(mk(1, 0, F_ADDSI, 15, 0, o(0,1,0,0,0,1,2,2,0,0,0,0,0,0)), "unk_after_rst");

        // Reset during a store handshake, then ORRS reg
        apply(mk(1, 1, F_STR, 7, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)), "rst_wr_fetch");
        apply(mk(1, 1, F_STR, 7, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)), "rst_wr_decode");
        apply(mk(1, 1, F_STR, 7, 1, o(2,0,0,0,0,0,1,0,0,0,0,0,0,0)), "rst_wr_adr");
        apply(mk(1, 1, F_STR, 7, 0, o(5,1,0,0,1,0,0,0,0,0,0,0,0,0)), "rst_wr_wait");
        apply(mk(0, 1, F_STR, 7, 1, o(5,0,0,0,1,0,0,0,0,0,0,0,0,0)), "rst_wr_forced");
        apply(mk(1, 0, F_ORRSR, 4, 1, o(0,1,1,1,0,1,2,2,0,0,0,0,0,0)), "orr_fetch");
        apply(mk(1, 0, F_ORRSR, 4, 1, o(1,0,0,0,0,1,2,2,0,0,0,0,0,0)), "orr_decode");
        apply(mk(1, 0, F_ORRSR, 4, 1, o(6,0,0,0,0,0,0,0,3,2,0,0,0,0)), "orr_exec");
        apply(mk(1, 0, F_ORRSR, 4, 1, o(8,0,0,0,0,0,0,0,0,0,1,0,0,0)), "orr_wb");
        apply(mk(1, 0, F_ORRSR, 4, 0, o(0,1,0,0,0,1,2,2,0,0,0,0,0,0)), "orr_done");

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
